fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the instruction buffer entries and the cap on in-flight requests (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port redirect  input  1  branch/jump taken; load new PC and flush.
REQ-006 The block SHALL have port redirect_pc  input  32  target address, valid when redirect=1.
REQ-007 The block SHALL have port imem_req_valid  output  1  fetch request present.
REQ-008 The block SHALL have port imem_req_addr  output  32  fetch address.
REQ-009 The block SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 The block SHALL have port imem_rsp_valid  input  1  instruction word returned; in order, at least 1 cycle after acceptance.
REQ-011 The block SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-012 The block SHALL have port inst_valid  output  1  buffered instruction available to decode.
REQ-013 The block SHALL have port inst_data  output  32  instruction at buffer head.
REQ-014 The block SHALL have port inst_pc  output  32  address of inst_data.
REQ-015 The block SHALL have port inst_ready  input  1  decode consumes the head entry this cycle.

Function
REQ-016 A request SHALL be accepted when imem_req_valid and imem_req_ready are both 1; a response SHALL be consumed when imem_rsp_valid=1; an instruction SHALL be popped when inst_valid and inst_ready are both 1.
REQ-017 imem_req_addr SHALL equal the fetch PC register; on each acceptance, fetch PC SHALL increment by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-018 imem_req_valid SHALL be 1 iff outstanding + buffer count < DEPTH; outstanding counts all accepted but unanswered requests, stale ones included.
REQ-019 Once raised, imem_req_valid and imem_req_addr SHALL hold stable until acceptance, except on redirect.
REQ-020 A response consumed while the discard counter is 0 SHALL be written to the buffer tail with its PC, taken from an expected-response PC register that then increments by 4.
REQ-021 A response consumed while the discard counter is nonzero SHALL be dropped, and the discard counter SHALL decrement.
REQ-022 Outstanding SHALL increment on acceptance and decrement on consumed response; both in the same cycle SHALL leave it unchanged.
REQ-023 The buffer SHALL be a DEPTH-entry FIFO with full throughput; push and pop in the same cycle SHALL leave the count unchanged.
REQ-024 Overflow SHALL be impossible, per REQ-018.
REQ-025 inst_valid SHALL equal (count != 0); inst_data and inst_pc SHALL be driven from the head entry.
REQ-026 On redirect=1, fetch PC and expected-response PC SHALL load redirect_pc, and the buffer SHALL be emptied.
REQ-027 On redirect=1, the discard counter SHALL load the outstanding value after that cycle's accept/response updates, so a request accepted in the redirect cycle is discarded and a response in the redirect cycle is dropped.
REQ-028 On redirect=1, the request presented that cycle SHALL carry the old address; the new address SHALL appear the next cycle.
REQ-029 A pop coinciding with redirect SHALL be permitted; the flush takes precedence.
REQ-030 Counters SHALL be sized to hold DEPTH without wrap.

Reset
REQ-031 While rst=0: fetch PC and expected-response PC = RESET_PC; outstanding, discard and count = 0; imem_req_valid=0, inst_valid=0; imem_req_addr=RESET_PC; inst_data=0; inst_pc=0.
REQ-032 imem_req_valid SHALL rise on the first clock edge after rst deasserts.
REQ-033 rst asserted mid-operation SHALL abandon all in-flight and buffered state immediately; responses after reset release are attributed as new.
REQ-034 The memory is reset on the same rst.

Verification
REQ-035 Streaming: rst release, ready=1, 1-cycle memory, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching data, one per cycle after 2-cycle fill.
REQ-036 Backpressure: inst_ready=0, DEPTH=4 -> exactly 4 requests (0..12) accepted, imem_req_valid drops, buffer full; inst_ready=1 -> fetch of 16 resumes.
REQ-037 Redirect with 3 outstanding, redirect_pc=32'h100 -> next request addr 32'h100; 3 stale responses dropped; first inst_pc=32'h100.
REQ-038 Simultaneous redirect + accept + response + pop -> buffer empty, discard equals post-update outstanding, no stale word reaches inst_*.
REQ-039 Wrap: redirect_pc=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Mid-operation rst pulse with 2 buffered and 2 outstanding -> all outputs at reset values while rst=0; first request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, buffers returned words with their PCs,
// and flushes/redirects on taken branches while discarding responses to stale requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   exp_pc, exp_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] head, head_nxt;
  logic [AW-1:0] tail, tail_nxt;

  logic [31:0] buf_data [DEPTH];
  logic [31:0] buf_pc   [DEPTH];

  logic [CW:0] inflight;
  logic        accept;
  logic        push;
  logic        pop;

  // Requests stay off for the reset cycle itself and come up on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_HOLD;
    endcase
  end

  // inflight only grows on acceptance, so a raised request can never drop on its own.
  always_comb begin
    inflight       = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid = (state == ST_RUN) && (inflight < DEPTH_SUM);
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && (discard == '0) && !redirect;
    inst_valid     = (count != '0);
    pop            = inst_valid && inst_ready && !redirect;
    inst_data      = inst_valid ? buf_data[head] : 32'h0;
    inst_pc        = inst_valid ? buf_pc[head] : 32'h0;
  end

  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, imem_rsp_valid})
      2'b10:   outstanding_nxt = outstanding + CNT_ONE;
      2'b01:   outstanding_nxt = outstanding - CNT_ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Everything still in flight after a redirect cycle belongs to the old path.
  always_comb begin
    discard_nxt = discard;
    if (redirect) begin
      discard_nxt = outstanding_nxt;
    end else if (imem_rsp_valid && (discard != '0)) begin
      discard_nxt = discard - CNT_ONE;
    end
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    exp_pc_nxt   = exp_pc;
    if (redirect) begin
      fetch_pc_nxt = redirect_pc;
      exp_pc_nxt   = redirect_pc;
    end else begin
      if (accept) begin
        fetch_pc_nxt = fetch_pc + 32'd4;
      end
      if (push) begin
        exp_pc_nxt = exp_pc + 32'd4;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    tail_nxt  = tail;
    if (redirect) begin
      count_nxt = '0;
      head_nxt  = '0;
      tail_nxt  = '0;
    end else begin
      if (push) begin
        tail_nxt = tail + PTR_ONE;
      end
      if (pop) begin
        head_nxt = head + PTR_ONE;
      end
      if (push && !pop) begin
        count_nxt = count + CNT_ONE;
      end else if (pop && !push) begin
        count_nxt = count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      exp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      exp_pc      <= exp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      count       <= count_nxt;
      head        <= head_nxt;
      tail        <= tail_nxt;
    end
  end

  // Storage needs no reset: outputs are gated by inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= imem_rsp_data;
      buf_pc[tail]   <= exp_pc;
    end
  end

endmodule
